uart_peer: RTL and testbench
============================

# uart_peer

Serial-line counterpart of the simulation UART. It deserializes the UART device's `tx` line into a byte stream and serializes bytes onto the device's `rx` line. It sits in the simulation top between the UART's serial pins and the host-side console/bench logic. Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), CLKS_PER_BIT clocks per bit, no parity.

## Interface
- `CLKS_PER_BIT`, 16: clocks per serial bit. Must be even and ≥4.
- `RX_DEPTH`, 16: receive FIFO entries. Must be a power of 2 and ≥2.
- `clock` in 1: single clock. All logic is on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `serial_in` in 1: connects to the UART `tx`. Idle high.
- `serial_out` out 1: connects to the UART `rx`. Idle high.
- `tx_valid` in 1: byte offered for transmission.
- `tx_data` in 8: byte to send.
- `tx_ready` out 1: transmitter idle. A handshake occurs when `tx_valid & tx_ready`.
- `rx_valid` out 1: RX FIFO non-empty.
- `rx_data` out 8: FIFO head byte. Reads 0 when empty.
- `rx_ready` in 1: pops the head when `rx_valid & rx_ready`.
- `rx_overrun` out 1: sticky. A good frame was dropped because the FIFO was full.
- `frame_err` out 1: sticky. The stop bit was sampled as 0.
- `clear_err` in 1: one-cycle pulse that clears both sticky flags.

## Operation
- **Reset (async, while `reset_n`=0):**
  - `serial_out`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, flags=0.
  - Both FSMs go to IDLE.
  - FIFO pointers and count are zeroed.
  - Synchronizer flops are set to 1.
  - Reset asserted mid-frame aborts that frame immediately. The partial byte is discarded and `serial_out` returns high asynchronously.
- **RX path:**
  - `serial_in` passes through a 2-flop synchronizer; the FSM uses the synchronized line `s`.
  - IDLE: on `s`=0, go to START with bit counter 0. Call this detection cycle D.
  - START: sample at D+N/2, where N=CLKS_PER_BIT.
    - If `s`=0, go to DATA.
    - If `s`=1, treat it as a glitch and return to IDLE with no flag.
  - DATA: sample data bit i (0..7) at D+N/2+(i+1)·N and shift it in LSB first.
  - STOP: sample at D+N/2+9·N, then return to IDLE on the same edge.
    - `s`=1, FIFO not full: push the byte.
    - `s`=1, FIFO full and no pop this cycle: drop the byte and set `rx_overrun`.
    - `s`=1, FIFO full with a pop this cycle: the push is accepted.
    - `s`=0: drop the byte and set `frame_err`.
- **RX FIFO:**
  - Show-ahead: `rx_data` is the head entry.
  - Count width is log2(RX_DEPTH)+1. Pointers wrap modulo RX_DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
  - A pop when empty is ignored.
- **TX path:**
  - IDLE, START, DATA, STOP. `tx_ready`=1 only in IDLE.
  - On handshake, latch `tx_data` and go to START.
  - `serial_out` is a registered output.
  - Start bit, each of the 8 data bits (LSB first) and the stop bit are each held exactly N cycles.
  - After the stop bit, return to IDLE.
  - `tx_valid` while busy is ignored; the data is not latched.
- **Sticky flags:** cleared by `clear_err`. If a set and a clear occur in the same cycle, set wins.

## Timing
- **TX:**
  - Handshake at edge T.
  - `serial_out`=0 from T to T+N.
  - Bit i is driven from T+(i+1)N to T+(i+2)N.
  - Stop bit from T+9N to T+10N.
  - `tx_ready`=1 from edge T+10N.
  - Minimum back-to-back frame period is 10N+1 cycles. The line stays high for at least 1 cycle between frames.
- **RX:**
  - D is 2–3 cycles after the `serial_in` falling edge (synchronizer latency).
  - The FIFO write happens at edge D+N/2+9N. `rx_valid` is high in the following cycle.
  - A new start bit is detectable from the cycle after the stop sample. This tolerates frames that start mid stop bit.
- **Pop:** the new head appears on `rx_data` the cycle after the pop edge.

## Test plan
- **Loopback:** tie `serial_out` to `serial_in` and send 0xA5, then 0x3C back-to-back. Expect `tx_ready` low for 10N cycles per byte, then `rx_data`=0xA5 followed by 0x3C, both flags 0.
- **TX waveform:** send 0x01 with N=16. Expect `serial_out` low for 16 cycles, high for 16, low for 112, then high (stop) for 16 cycles.
- **Stop-bit error:** drive a frame of 0x55 with stop bit 0. Expect `frame_err`=1, `rx_valid`=0. Then pulse `clear_err`: `frame_err`=0.
- **Overrun:** hold `rx_ready`=0 and drive RX_DEPTH+1 frames (0x00..0x10).
  - `rx_overrun`=1.
  - Popping returns exactly 0x00..0x0F.
  - Push with a same-cycle pop while full is accepted.
- **Glitch and reset:**
  - A 3-cycle low pulse on `serial_in` produces no byte and no flag.
  - Asserting `reset_n`=0 mid-TX frame forces `serial_out`=1 immediately. After release, `tx_ready`=1 and the FIFO is empty.

Source files
------------

// File: rtl/uart_peer.sv
// Serial-line counterpart of the simulation UART: deserializes the device tx line
// into a show-ahead byte FIFO and serializes host bytes onto the device rx line.
module uart_peer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RX_DEPTH     = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic       serial_out,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       frame_err,
  input  logic       clear_err
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(RX_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // ---------------- RX synchronizer and FSM ----------------
  logic [1:0]       sync_reg;
  logic             s;
  state_t           rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic             rx_stop_sample;

  assign s = sync_reg[1];

  always_comb begin
    rx_state_next  = rx_state_reg;
    rx_cnt_next    = rx_cnt_reg;
    rx_bit_next    = rx_bit_reg;
    rx_shift_next  = rx_shift_reg;
    rx_stop_sample = 1'b0;
    case (rx_state_reg)
      ST_IDLE: begin
        if (!s) begin
          rx_state_next = ST_START;
          rx_cnt_next   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          // A line that is high again at mid start bit was only a glitch
          rx_state_next = s ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {s, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) rx_state_next = ST_STOP;
          else                    rx_bit_next   = rx_bit_reg + 1'b1;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_stop_sample = 1'b1;
          rx_cnt_next    = '0;
          rx_state_next  = ST_IDLE;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg     <= 2'b11;
      rx_state_reg <= ST_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      sync_reg     <= {sync_reg[0], serial_in};
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [7:0]        mem [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0] count_reg, count_next;
  logic              fifo_full, pop, push_try, push, overrun_set, ferr_set;
  logic              rx_overrun_reg, frame_err_reg;

  assign fifo_full   = (count_reg == FCNT_W'(RX_DEPTH));
  assign pop         = rx_ready && (count_reg != '0);
  assign push_try    = rx_stop_sample && s;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte
  assign push        = push_try && (!fifo_full || pop);
  assign overrun_set = push_try && fifo_full && !pop;
  assign ferr_set    = rx_stop_sample && !s;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= rx_shift_reg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rx_overrun_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      if (overrun_set)    rx_overrun_reg <= 1'b1;
      else if (clear_err) rx_overrun_reg <= 1'b0;
      if (ferr_set)       frame_err_reg  <= 1'b1;
      else if (clear_err) frame_err_reg  <= 1'b0;
    end
  end

  assign rx_valid   = (count_reg != '0);
  assign rx_data    = rx_valid ? mem[rd_ptr_reg] : 8'h00;
  assign rx_overrun = rx_overrun_reg;
  assign frame_err  = frame_err_reg;

  // ---------------- TX FSM ----------------
  state_t           tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic             serial_out_reg, serial_out_next;

  always_comb begin
    tx_state_next   = tx_state_reg;
    tx_cnt_next     = tx_cnt_reg;
    tx_bit_next     = tx_bit_reg;
    tx_shift_next   = tx_shift_reg;
    serial_out_next = serial_out_reg;
    case (tx_state_reg)
      ST_IDLE: begin
        serial_out_next = 1'b1;
        if (tx_valid) begin
          tx_shift_next   = tx_data;
          tx_cnt_next     = '0;
          serial_out_next = 1'b0;
          tx_state_next   = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next     = '0;
          tx_bit_next     = '0;
          serial_out_next = tx_shift_reg[0];
          tx_state_next   = ST_DATA;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == 3'd7) begin
            serial_out_next = 1'b1;
            tx_state_next   = ST_STOP;
          end else begin
            tx_bit_next     = tx_bit_reg + 1'b1;
            tx_shift_next   = {1'b0, tx_shift_reg[7:1]};
            serial_out_next = tx_shift_reg[1];
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = ST_IDLE;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      default: tx_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_reg   <= ST_IDLE;
      tx_cnt_reg     <= '0;
      tx_bit_reg     <= '0;
      tx_shift_reg   <= '0;
      serial_out_reg <= 1'b1;
    end else begin
      tx_state_reg   <= tx_state_next;
      tx_cnt_reg     <= tx_cnt_next;
      tx_bit_reg     <= tx_bit_next;
      tx_shift_reg   <= tx_shift_next;
      serial_out_reg <= serial_out_next;
    end
  end

  assign serial_out = serial_out_reg;
  assign tx_ready   = (tx_state_reg == ST_IDLE);

endmodule

// File: tb/tb_uart_peer.sv
// Directed bench for uart_peer: TX waveform, loopback, frame error, overrun,
// glitch rejection and asynchronous reset mid-frame.
module tb_uart_peer;

  localparam int N     = 16;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_in;
  logic       serial_out;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       rx_overrun;
  logic       frame_err;
  logic       clear_err = 1'b0;
  logic       loop = 1'b0;
  logic       drv = 1'b1;

  int checks = 0;
  int errors = 0;

  assign serial_in = loop ? serial_out : drv;

  always #5 clock = ~clock;

  uart_peer #(.CLKS_PER_BIT(N), .RX_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .clear_err  (clear_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one frame on serial_in; pop_k > 0 raises rx_ready for the stop-sample edge
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int pop_k);
    drv = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      drv = b[i];
      repeat (N) tick();
    end
    drv = stop;
    for (int k = 1; k <= N; k++) begin
      rx_ready = (k == pop_k);
      tick();
      rx_ready = 1'b0;
    end
    drv = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, output int busy);
    int w;
    w = 0;
    while (!tx_ready && w < 2000) begin
      tick();
      w++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    busy = 0;
    while (!tx_ready && busy < 2000) begin
      busy++;
      tick();
    end
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    int busy;
    int bad;
    int rdy_bad;
    logic exp_bit;

    // Reset state
    repeat (3) tick();
    check("rst_serial_out", serial_out, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_flags", {rx_overrun, frame_err}, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    $display("reset released: serial_out=%0b tx_ready=%0b", serial_out, tx_ready);

    // TX waveform for 0x01, with a tx_valid pulse while busy that must be ignored
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    bad = 0;
    rdy_bad = 0;
    for (int j = 0; j < 10 * N; j++) begin
      exp_bit = (j < N) ? 1'b0 : (j < 2 * N) ? 1'b1 : (j < 9 * N) ? 1'b0 : 1'b1;
      if (serial_out !== exp_bit) bad++;
      if (tx_ready !== 1'b0) rdy_bad++;
      if (j == 50) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      tick();
      if (j == 50) tx_valid = 1'b0;
    end
    check("tx_wave_bits", bad, 0);
    check("tx_wave_busy", rdy_bad, 0);
    check("tx_wave_ready_after", tx_ready, 1);
    repeat (10) tick();
    check("tx_busy_valid_ignored", {tx_ready, serial_out}, 2'b11);
    check("tx_wave_no_rx", rx_valid, 0);
    $display("tx 0x01 waveform: bit errors=%0d busy errors=%0d", bad, rdy_bad);

    // Loopback 0xA5 then 0x3C
    loop = 1'b1;
    send_byte(8'hA5, busy);
    check("loop_busy_a5", busy, 10 * N);
    $display("loopback tx 0xa5 busy=%0d", busy);
    send_byte(8'h3C, busy);
    check("loop_busy_3c", busy, 10 * N);
    $display("loopback tx 0x3c busy=%0d", busy);
    repeat (20) tick();
    check("loop_rx_valid", rx_valid, 1);
    check("loop_rx_first", rx_data, 8'hA5);
    pop_one();
    check("loop_rx_second", rx_data, 8'h3C);
    pop_one();
    check("loop_rx_empty", rx_valid, 0);
    check("loop_flags", {rx_overrun, frame_err}, 0);
    loop = 1'b0;

    // Stop bit sampled low
    drive_frame(8'h55, 1'b0, 0);
    repeat (20) tick();
    check("ferr_set", frame_err, 1);
    check("ferr_no_data", rx_valid, 0);
    check("ferr_no_overrun", rx_overrun, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("ferr_cleared", frame_err, 0);
    $display("frame error 0x55: flag set then cleared");

    // Overrun: DEPTH+1 frames with no pops
    for (int i = 0; i <= DEPTH; i++) drive_frame(8'(i), 1'b1, 0);
    check("ovr_set", rx_overrun, 1);
    check("ovr_valid", rx_valid, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovr_pop_%0d", i), rx_data, 32'(i));
      pop_one();
    end
    check("ovr_empty", rx_valid, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("ovr_cleared", rx_overrun, 0);
    $display("overrun: flag set, %0d bytes popped", DEPTH);

    // Push into a full FIFO with a pop on the stop-sample edge
    for (int i = 0; i < DEPTH; i++) drive_frame(8'h20 + 8'(i), 1'b1, 0);
    drive_frame(8'h77, 1'b1, 11);
    check("full_pop_no_overrun", rx_overrun, 0);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("full_pop_%0d", i), rx_data, 32'h20 + 32'(i));
      pop_one();
    end
    check("full_pop_last", rx_data, 8'h77);
    pop_one();
    check("full_pop_empty", rx_valid, 0);
    $display("push while full with same-cycle pop accepted");

    // 3-cycle glitch
    drv = 1'b0;
    repeat (3) tick();
    drv = 1'b1;
    repeat (40) tick();
    check("glitch_no_data", rx_valid, 0);
    check("glitch_no_flags", {rx_overrun, frame_err}, 0);
    $display("glitch: rx_valid=%0b flags=%0b%0b", rx_valid, rx_overrun, frame_err);

    // Reset in the middle of a TX frame with a byte queued in the FIFO
    drive_frame(8'h42, 1'b1, 0);
    check("pre_rst_data", rx_data, 8'h42);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (50) tick();
    check("mid_tx_low", serial_out, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_serial_out", serial_out, 1);
    check("async_rst_tx_ready", tx_ready, 1);
    check("async_rst_rx_valid", rx_valid, 0);
    #2;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("post_rst_ready", tx_ready, 1);
    check("post_rst_empty", {rx_valid, rx_data}, 0);
    check("post_rst_line", serial_out, 1);
    $display("reset mid-tx: serial_out=%0b tx_ready=%0b rx_valid=%0b", serial_out, tx_ready, rx_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
